// File: rtl/truth_table_checker.sv
// Self-test engine: sweeps all 2^N input codes into a combinational DUT,
// samples its output after a settle cycle and counts mismatches against TRUTH.
module truth_table_checker #(
  parameter int unsigned         N     = 3,
  parameter logic [(2**N)-1:0]   TRUTH = 8'h39,
  parameter int unsigned         ERRW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N-1:0]    stim,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] errors,
  output logic            err_valid,
  output logic [N-1:0]    err_vec
);

  localparam logic [N-1:0]    LAST_CODE = {N{1'b1}};
  localparam logic [ERRW-1:0] ERR_MAX   = {ERRW{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [ERRW-1:0] errors_q, errors_d;
  logic            err_valid_q, err_valid_d;
  logic [N-1:0]    err_vec_q, err_vec_d;
  logic            mismatch_c;

  assign mismatch_c = (dut_y != TRUTH[stim_q]);

  // Next-state and next-output logic; every output is a flop.
  always_comb begin
    state_d     = state_q;
    stim_d      = stim_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    errors_d    = errors_q;
    err_valid_d = 1'b0;
    err_vec_d   = err_vec_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = DRIVE;
          stim_d   = '0;
          errors_d = '0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
        end
      end

      DRIVE: begin
        state_d = SAMPLE;
      end

      SAMPLE: begin
        if (mismatch_c) begin
          err_valid_d = 1'b1;
          err_vec_d   = stim_q;
          if (errors_q != ERR_MAX) begin
            errors_d = errors_q + ERRW'(1);
          end
        end
        // Last code ends the sweep without incrementing stim, so it never wraps.
        if (stim_q == LAST_CODE) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (errors_d == '0);
        end else begin
          state_d = DRIVE;
          stim_d  = stim_q + N'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      stim_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      errors_q    <= '0;
      err_valid_q <= 1'b0;
      err_vec_q   <= '0;
    end else begin
      state_q     <= state_d;
      stim_q      <= stim_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      errors_q    <= errors_d;
      err_valid_q <= err_valid_d;
      err_vec_q   <= err_vec_d;
    end
  end

  assign stim      = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign errors    = errors_q;
  assign err_valid = err_valid_q;
  assign err_vec   = err_vec_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: default 3-input table, a saturating ERRW=2
// instance and an N=2 XOR instance, each driving a modelled combinational DUT.
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference function y = a&~b | ~b&~c | ~a&b&c, code {a,b,c}
  function automatic logic ref_y(input logic [2:0] s);
    logic a, b, c;
    {a, b, c} = s;
    return (a & ~b) | (~b & ~c) | (~a & b & c);
  endfunction

  // DUT models: 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 inverted, 4 code 6 flipped
  function automatic logic dut_fn(input logic [2:0] s, input int m);
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ~ref_y(s);
      4:       return (s == 3'd6) ? ~ref_y(s) : ref_y(s);
      default: return ref_y(s);
    endcase
  endfunction

  int mode;

  // Instance A: defaults
  logic       start_a, y_a, busy_a, done_a, pass_a, ev_a;
  logic [2:0] stim_a, vec_a;
  logic [7:0] errors_a;
  assign y_a = dut_fn(stim_a, mode);

  truth_table_checker dut_a (
    .clk(clk), .reset(reset), .start(start_a), .stim(stim_a), .dut_y(y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .errors(errors_a),
    .err_valid(ev_a), .err_vec(vec_a)
  );

  // Instance B: ERRW=2, inverted DUT
  logic       start_b, y_b, busy_b, done_b, pass_b, ev_b;
  logic [2:0] stim_b, vec_b;
  logic [1:0] errors_b;
  assign y_b = ~ref_y(stim_b);

  truth_table_checker #(.N(3), .TRUTH(8'h39), .ERRW(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .stim(stim_b), .dut_y(y_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .errors(errors_b),
    .err_valid(ev_b), .err_vec(vec_b)
  );

  // Instance C: N=2 XOR
  logic       start_c, y_c, busy_c, done_c, pass_c, ev_c;
  logic [1:0] stim_c, vec_c;
  logic [7:0] errors_c;
  assign y_c = stim_c[1] ^ stim_c[0];

  truth_table_checker #(.N(2), .TRUTH(4'b0110), .ERRW(8)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .stim(stim_c), .dut_y(y_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .errors(errors_c),
    .err_valid(ev_c), .err_vec(vec_c)
  );

  typedef struct {
    int         mode;
    int         errs;
    logic [2:0] vec;
    logic       pass;
  } case_t;

  case_t tbl [5];
  logic [2:0] last_vec;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full sweep on instance A, checked cycle by cycle against the model
  task automatic run_sweep(input int t);
    int pulses;
    pulses = 0;
    mode = tbl[t].mode;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("restart_errors", 32'(errors_a), 0);
    chk("restart_vec", 32'(vec_a), 32'(last_vec));
    for (int c = 1; c <= 17; c++) begin
      logic exp_ev;
      logic [2:0] kk;
      kk = 3'((c - 3) / 2);
      exp_ev = (c >= 3 && (c % 2) == 1) ? (dut_fn(kk, mode) != ref_y(kk)) : 1'b0;
      if (c <= 16) begin
        chk("sweep_stim", 32'(stim_a), (c - 1) / 2);
        chk("sweep_busy", 32'(busy_a), 1);
        chk("sweep_done", 32'(done_a), 0);
      end else begin
        chk("end_stim", 32'(stim_a), 7);
        chk("end_busy", 32'(busy_a), 0);
        chk("end_done", 32'(done_a), 1);
      end
      chk("sweep_err_valid", 32'(ev_a), 32'(exp_ev));
      if (ev_a) pulses++;
      if (c < 17) tick();
    end
    chk("end_errors", 32'(errors_a), tbl[t].errs);
    chk("end_err_vec", 32'(vec_a), 32'(tbl[t].vec));
    chk("end_pass", 32'(pass_a), 32'(tbl[t].pass));
    chk("end_pulses", pulses, tbl[t].errs);
    last_vec = tbl[t].vec;
  endtask

  initial begin
    tbl[0] = '{mode: 0, errs: 0, vec: 3'd0, pass: 1'b1};
    tbl[1] = '{mode: 1, errs: 4, vec: 3'd5, pass: 1'b0};
    tbl[2] = '{mode: 2, errs: 4, vec: 3'd7, pass: 1'b0};
    tbl[3] = '{mode: 4, errs: 1, vec: 3'd6, pass: 1'b0};
    tbl[4] = '{mode: 3, errs: 8, vec: 3'd7, pass: 1'b0};

    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    mode = 0;
    last_vec = 3'd0;
    tick(); tick();
    chk("rst_stim", 32'(stim_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_pass", 32'(pass_a), 0);
    chk("rst_errors", 32'(errors_a), 0);
    chk("rst_err_valid", 32'(ev_a), 0);
    chk("rst_err_vec", 32'(vec_a), 0);
    reset = 1'b0;
    tick();

    for (int t = 0; t < 5; t++) run_sweep(t);

    // Reset mid-sweep, asserted in cycle 6
    mode = 3;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (5) tick();
    chk("pre_abort_errors", 32'(errors_a), 2);
    chk("pre_abort_vec", 32'(vec_a), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_stim", 32'(stim_a), 0);
    chk("abort_busy", 32'(busy_a), 0);
    chk("abort_done", 32'(done_a), 0);
    chk("abort_errors", 32'(errors_a), 0);
    chk("abort_err_vec", 32'(vec_a), 0);
    tick();
    chk("abort_idle_busy", 32'(busy_a), 0);
    last_vec = 3'd0;
    run_sweep(0);

    // start held high throughout: ignored while busy, immediate restart after DONE
    mode = 1;
    start_a = 1'b1;
    tick();
    repeat (9) tick();
    chk("held_stim_c10", 32'(stim_a), 4);
    chk("held_busy_c10", 32'(busy_a), 1);
    repeat (7) tick();
    chk("held_done_c17", 32'(done_a), 1);
    chk("held_errors_c17", 32'(errors_a), 4);
    tick();
    chk("held_done_c18", 32'(done_a), 0);
    chk("held_busy_c18", 32'(busy_a), 1);
    chk("held_errors_c18", 32'(errors_a), 0);
    chk("held_stim_c18", 32'(stim_a), 0);
    start_a = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // ERRW=2 saturation with an inverted DUT
    begin
      int pulses_b;
      pulses_b = 0;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int c = 1; c <= 17; c++) begin
        if (ev_b) pulses_b++;
        if (c == 7) chk("sat_errors_c7", 32'(errors_b), 3);
        if (c == 11) chk("sat_errors_c11", 32'(errors_b), 3);
        if (c < 17) tick();
      end
      chk("sat_done", 32'(done_b), 1);
      chk("sat_errors", 32'(errors_b), 3);
      chk("sat_pulses", pulses_b, 8);
      chk("sat_err_vec", 32'(vec_b), 7);
      chk("sat_pass", 32'(pass_b), 0);
    end

    // N=2 XOR instance finishes in cycle 9
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c <= 8) chk("xor_busy", 32'(busy_c), 1);
      if (c == 8) chk("xor_done_c8", 32'(done_c), 0);
      chk("xor_err_valid", 32'(ev_c), 0);
      if (c < 9) tick();
    end
    chk("xor_done_c9", 32'(done_c), 1);
    chk("xor_pass", 32'(pass_c), 1);
    chk("xor_errors", 32'(errors_c), 0);
    chk("xor_stim", 32'(stim_c), 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
